// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM arbitration slice.
package sdram_pkg;

  localparam int unsigned SDRAM_ADDR_W = 24;
  localparam int unsigned SDRAM_DATA_W = 32;
  localparam int unsigned SDRAM_LEN_W  = 8;

  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational request picker: rotating search from ptr, or fixed lowest-index-first.
module rr_pick #(
  parameter int unsigned N = 4,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             rr_en,
  output logic             valid,
  output logic [N-1:0]     grant_oh,
  output logic [IDX_W-1:0] grant_idx
);

  int unsigned      j;
  logic [IDX_W-1:0] idx;

  // First requester encountered in search order wins.
  always_comb begin
    valid     = 1'b0;
    grant_oh  = '0;
    grant_idx = '0;
    j         = 0;
    idx       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j   = rr_en ? ((32'(ptr) + k) % N) : k;
      idx = IDX_W'(j);
      if (!valid && req[idx]) begin
        valid         = 1'b1;
        grant_oh[idx] = 1'b1;
        grant_idx     = idx;
      end
    end
  end

endmodule

// File: rtl/sdram_arb_rr.sv
// N-port SDRAM core arbiter with zero-latency forwarding and grant held until core ack.
module sdram_arb_rr
  import sdram_pkg::*;
#(
  parameter int unsigned NPORTS  = 4,
  parameter int unsigned ADDR_W  = SDRAM_ADDR_W,
  parameter int unsigned DATA_W  = SDRAM_DATA_W,
  parameter int unsigned LEN_W   = SDRAM_LEN_W,
  parameter int unsigned MASK_W  = DATA_W / 8,
  parameter int unsigned RR_MODE = ARB_RR
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NPORTS-1:0]        p_rd,
  input  logic [NPORTS*MASK_W-1:0] p_wr,
  input  logic [NPORTS*LEN_W-1:0]  p_len,
  input  logic [NPORTS*ADDR_W-1:0] p_addr,
  input  logic [NPORTS*DATA_W-1:0] p_wdata,
  output logic [NPORTS-1:0]        p_accept,
  output logic [NPORTS-1:0]        p_ack,
  output logic [NPORTS-1:0]        p_error,
  output logic [NPORTS*DATA_W-1:0] p_rdata,
  output logic                     c_rd,
  output logic [MASK_W-1:0]        c_wr,
  output logic [LEN_W-1:0]         c_len,
  output logic [ADDR_W-1:0]        c_addr,
  output logic [DATA_W-1:0]        c_wdata,
  input  logic                     c_accept,
  input  logic                     c_ack,
  input  logic                     c_error,
  input  logic [DATA_W-1:0]        c_rdata,
  output logic [NPORTS-1:0]        grant,
  output logic                     busy
);

  localparam int unsigned PTR_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  arb_state_e       state_q, state_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;

  logic [NPORTS-1:0] req;
  logic              win_valid;
  logic [NPORTS-1:0] win_oh;
  logic [PTR_W-1:0]  win_idx;
  logic              sel_valid;
  logic [PTR_W-1:0]  sel_idx;

  always_comb begin
    req = '0;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      req[i] = p_rd[i] | (|p_wr[i*MASK_W +: MASK_W]);
    end
  end

  rr_pick #(.N(NPORTS)) u_pick (
    .req      (req),
    .ptr      (ptr_q),
    .rr_en    (RR_MODE == ARB_RR),
    .valid    (win_valid),
    .grant_oh (win_oh),
    .grant_idx(win_idx)
  );

  // Ownership: held through BUSY, taken by the combinational winner in IDLE.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    sel_valid = 1'b0;
    sel_idx   = '0;
    if (state_q == ARB_BUSY) begin
      sel_valid = 1'b1;
      sel_idx   = owner_q;
      if (c_ack) begin
        state_d = ARB_IDLE;
      end
    end else if (win_valid) begin
      sel_valid = 1'b1;
      sel_idx   = win_idx;
      state_d   = ARB_BUSY;
      owner_d   = win_idx;
      if (RR_MODE == ARB_RR) begin
        ptr_d = (32'(win_idx) == NPORTS - 1) ? '0 : PTR_W'(win_idx + PTR_W'(1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  // Request mux toward the core and response demux back to the selected port.
  always_comb begin
    grant    = '0;
    c_rd     = 1'b0;
    c_wr     = '0;
    c_len    = '0;
    c_addr   = '0;
    c_wdata  = '0;
    p_accept = '0;
    p_ack    = '0;
    p_error  = '0;
    p_rdata  = '0;
    if (sel_valid) begin
      grant[sel_idx]    = 1'b1;
      c_rd              = p_rd[sel_idx];
      c_wr              = p_wr[32'(sel_idx)*MASK_W +: MASK_W];
      c_len             = p_len[32'(sel_idx)*LEN_W +: LEN_W];
      c_addr            = p_addr[32'(sel_idx)*ADDR_W +: ADDR_W];
      c_wdata           = p_wdata[32'(sel_idx)*DATA_W +: DATA_W];
      p_accept[sel_idx] = c_accept;
      p_ack[sel_idx]    = c_ack;
      p_error[sel_idx]  = c_error;
      p_rdata[32'(sel_idx)*DATA_W +: DATA_W] = c_rdata;
    end
  end

  assign busy = (state_q == ARB_BUSY);

endmodule

// File: tb/tb_sdram_arb_rr.sv
// Directed bench for sdram_arb_rr: a round-robin and a fixed-priority instance share stimulus.
module tb_sdram_arb_rr;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 24;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 8;
  localparam int unsigned MW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      p_rd;
  logic [N*MW-1:0]   p_wr;
  logic [N*LW-1:0]   p_len;
  logic [N*AW-1:0]   p_addr;
  logic [N*DW-1:0]   p_wdata;
  logic              c_accept, c_ack, c_error;
  logic [DW-1:0]     c_rdata;

  logic [N-1:0]      p_accept_r, p_ack_r, p_error_r, grant_r;
  logic [N*DW-1:0]   p_rdata_r;
  logic              c_rd_r, busy_r;
  logic [MW-1:0]     c_wr_r;
  logic [LW-1:0]     c_len_r;
  logic [AW-1:0]     c_addr_r;
  logic [DW-1:0]     c_wdata_r;

  logic [N-1:0]      p_accept_f, p_ack_f, p_error_f, grant_f;
  logic [N*DW-1:0]   p_rdata_f;
  logic              c_rd_f, busy_f;
  logic [MW-1:0]     c_wr_f;
  logic [LW-1:0]     c_len_f;
  logic [AW-1:0]     c_addr_f;
  logic [DW-1:0]     c_wdata_f;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sdram_arb_rr #(.NPORTS(N), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .MASK_W(MW), .RR_MODE(1)) dut_rr (
    .clk(clk), .rst(rst), .p_rd(p_rd), .p_wr(p_wr), .p_len(p_len), .p_addr(p_addr),
    .p_wdata(p_wdata), .p_accept(p_accept_r), .p_ack(p_ack_r), .p_error(p_error_r),
    .p_rdata(p_rdata_r), .c_rd(c_rd_r), .c_wr(c_wr_r), .c_len(c_len_r), .c_addr(c_addr_r),
    .c_wdata(c_wdata_r), .c_accept(c_accept), .c_ack(c_ack), .c_error(c_error),
    .c_rdata(c_rdata), .grant(grant_r), .busy(busy_r)
  );

  sdram_arb_rr #(.NPORTS(N), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .MASK_W(MW), .RR_MODE(0)) dut_fx (
    .clk(clk), .rst(rst), .p_rd(p_rd), .p_wr(p_wr), .p_len(p_len), .p_addr(p_addr),
    .p_wdata(p_wdata), .p_accept(p_accept_f), .p_ack(p_ack_f), .p_error(p_error_f),
    .p_rdata(p_rdata_f), .c_rd(c_rd_f), .c_wr(c_wr_f), .c_len(c_len_f), .c_addr(c_addr_f),
    .c_wdata(c_wdata_f), .c_accept(c_accept), .c_ack(c_ack), .c_error(c_error),
    .c_rdata(c_rdata), .grant(grant_f), .busy(busy_f)
  );

  task automatic clear_inputs();
    p_rd = '0; p_wr = '0; p_len = '0; p_addr = '0; p_wdata = '0;
    c_accept = 1'b0; c_ack = 1'b0; c_error = 1'b0; c_rdata = '0;
  endtask

  // Leaves the bench at a negedge with rst low and both instances reset.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (grant_r !== 4'b0000 || busy_r !== 1'b0) begin
      failures++; $display("FAIL reset_rr grant=%b busy=%b expected grant=0000 busy=0", grant_r, busy_r);
    end
    checks++;
    if (grant_f !== 4'b0000 || busy_f !== 1'b0) begin
      failures++; $display("FAIL reset_fx grant=%b busy=%b expected grant=0000 busy=0", grant_f, busy_f);
    end
    checks++;
    if (c_rd_r !== 1'b0 || c_wr_r !== 4'h0 || c_addr_r !== 24'h0 || p_ack_r !== 4'h0 || p_rdata_r !== '0) begin
      failures++; $display("FAIL reset_outputs c_rd=%b c_wr=%h c_addr=%h p_ack=%b expected all 0",
                           c_rd_r, c_wr_r, c_addr_r, p_ack_r);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    p_rd = 4'b0100;
    p_addr[2*AW +: AW] = 24'h000100;
    p_len[2*LW +: LW]  = 8'd4;
    #1;
    checks++;
    if (c_rd_r !== 1'b1 || c_addr_r !== 24'h000100 || c_len_r !== 8'd4 || c_wr_r !== 4'h0) begin
      failures++; $display("FAIL single_fwd c_rd=%b c_addr=%h c_len=%0d c_wr=%h expected 1 000100 4 0",
                           c_rd_r, c_addr_r, c_len_r, c_wr_r);
    end
    checks++;
    if (grant_r !== 4'b0100 || busy_r !== 1'b0) begin
      failures++; $display("FAIL single_grant grant=%b busy=%b expected 0100 0", grant_r, busy_r);
    end
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk); #1;
      checks++;
      if (busy_r !== 1'b1 || grant_r !== 4'b0100 || p_ack_r !== 4'b0000) begin
        failures++; $display("FAIL single_hold cyc=%0d busy=%b grant=%b p_ack=%b expected 1 0100 0000",
                             c, busy_r, grant_r, p_ack_r);
      end
    end
    @(negedge clk);
    c_ack = 1'b1; c_rdata = 32'h12345678;
    #1;
    checks++;
    if (p_ack_r !== 4'b0100) begin
      failures++; $display("FAIL single_ack p_ack=%b expected 0100", p_ack_r);
    end
    checks++;
    if (p_rdata_r !== {32'h0, 32'h12345678, 32'h0, 32'h0}) begin
      failures++; $display("FAIL single_rdata p_rdata=%h expected port2 slice 12345678 only", p_rdata_r);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (busy_r !== 1'b0 || grant_r !== 4'b0000) begin
      failures++; $display("FAIL single_idle busy=%b grant=%b expected 0 0000", busy_r, grant_r);
    end
    // Pointer now sits at 3, so port 3 beats port 0.
    @(negedge clk);
    p_rd = 4'b1001;
    #1;
    checks++;
    if (grant_r !== 4'b1000) begin
      failures++; $display("FAIL single_ptr grant=%b expected 1000", grant_r);
    end
  endtask

  task automatic run_all_ports(input bit use_rr);
    logic [N-1:0] g, a, exp_g;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      exp_g = use_rr ? (4'b0001 << (k % 4)) : 4'b0001;
      p_rd = 4'hF; c_ack = 1'b0;
      #1;
      g = use_rr ? grant_r : grant_f;
      checks++;
      if (g !== exp_g || (use_rr ? busy_r : busy_f) !== 1'b0) begin
        failures++; $display("FAIL all_grant rr=%0d k=%0d grant=%b expected %b with busy 0", use_rr, k, g, exp_g);
      end
      for (int c = 0; c < 2; c++) begin
        @(negedge clk); #1;
        g = use_rr ? grant_r : grant_f;
        checks++;
        if (g !== exp_g || (use_rr ? busy_r : busy_f) !== 1'b1) begin
          failures++; $display("FAIL all_hold rr=%0d k=%0d grant=%b expected %b with busy 1", use_rr, k, g, exp_g);
        end
      end
      @(negedge clk);
      c_ack = 1'b1;
      #1;
      a = use_rr ? p_ack_r : p_ack_f;
      checks++;
      if (a !== exp_g) begin
        failures++; $display("FAIL all_ack rr=%0d k=%0d p_ack=%b expected %b", use_rr, k, a, exp_g);
      end
      @(negedge clk);
    end
    clear_inputs();
  endtask

  task automatic test_round_robin();
    run_all_ports(1'b1);
  endtask

  task automatic test_fixed_priority();
    run_all_ports(1'b0);
  endtask

  task automatic test_busy_blocking();
    do_reset();
    p_rd = 4'b0010;
    p_addr[1*AW +: AW] = 24'h000AAA;
    p_addr[0*AW +: AW] = 24'h000555;
    p_wdata[0*DW +: DW] = 32'hCAFEF00D;
    #1;
    checks++;
    if (grant_r !== 4'b0010) begin
      failures++; $display("FAIL block_grant1 grant=%b expected 0010", grant_r);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      p_wr[0*MW +: MW] = 4'hF;
      #1;
      checks++;
      if (c_wr_r !== 4'h0 || c_addr_r !== 24'h000AAA || grant_r !== 4'b0010) begin
        failures++; $display("FAIL block_hold cyc=%0d c_wr=%h c_addr=%h grant=%b expected 0 000aaa 0010",
                             c, c_wr_r, c_addr_r, grant_r);
      end
    end
    @(negedge clk);
    c_ack = 1'b1;
    #1;
    checks++;
    if (p_ack_r !== 4'b0010 || c_wr_r !== 4'h0) begin
      failures++; $display("FAIL block_ack p_ack=%b c_wr=%h expected 0010 0", p_ack_r, c_wr_r);
    end
    @(negedge clk);
    c_ack = 1'b0;
    #1;
    checks++;
    if (grant_r !== 4'b0001 || c_wr_r !== 4'hF || c_addr_r !== 24'h000555 || c_wdata_r !== 32'hCAFEF00D) begin
      failures++; $display("FAIL block_grant0 grant=%b c_wr=%h c_addr=%h c_wdata=%h expected 0001 f 000555 cafef00d",
                           grant_r, c_wr_r, c_addr_r, c_wdata_r);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_txn();
    do_reset();
    p_rd = 4'b1000;
    #1;
    checks++;
    if (grant_r !== 4'b1000) begin
      failures++; $display("FAIL midrst_grant grant=%b expected 1000", grant_r);
    end
    @(negedge clk); #1;
    checks++;
    if (busy_r !== 1'b1) begin
      failures++; $display("FAIL midrst_busy busy=%b expected 1", busy_r);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    p_rd = 4'b0000;
    #1;
    checks++;
    if (grant_r !== 4'b0000 || busy_r !== 1'b0 || c_rd_r !== 1'b0 || c_wr_r !== 4'h0) begin
      failures++; $display("FAIL midrst_clear grant=%b busy=%b c_rd=%b c_wr=%h expected 0000 0 0 0",
                           grant_r, busy_r, c_rd_r, c_wr_r);
    end
    @(negedge clk);
    p_rd = 4'b1010;
    #1;
    checks++;
    if (grant_r !== 4'b0010) begin
      failures++; $display("FAIL midrst_regrant grant=%b expected 0010", grant_r);
    end
    clear_inputs();
  endtask

  task automatic test_spurious_ack();
    do_reset();
    c_ack = 1'b1; c_rdata = 32'hDEADBEEF; c_accept = 1'b1; c_error = 1'b1;
    #1;
    checks++;
    if (p_ack_r !== 4'h0 || p_rdata_r !== '0 || p_accept_r !== 4'h0 || p_error_r !== 4'h0) begin
      failures++; $display("FAIL spurious_rr p_ack=%b p_accept=%b p_error=%b p_rdata=%h expected all 0",
                           p_ack_r, p_accept_r, p_error_r, p_rdata_r);
    end
    checks++;
    if (p_ack_f !== 4'h0 || p_rdata_f !== '0) begin
      failures++; $display("FAIL spurious_fx p_ack=%b p_rdata=%h expected all 0", p_ack_f, p_rdata_f);
    end
    @(negedge clk); #1;
    checks++;
    if (busy_r !== 1'b0 || grant_r !== 4'h0 || p_ack_r !== 4'h0) begin
      failures++; $display("FAIL spurious_idle busy=%b grant=%b p_ack=%b expected 0 0000 0000",
                           busy_r, grant_r, p_ack_r);
    end
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_fixed_priority();
    test_busy_blocking();
    test_reset_mid_txn();
    test_spurious_ack();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
